datapath_legv8_seq: RTL
=======================

// Module: datapath_legv8_seq
// PURPOSE
//  Parametrised, multi-cycle successor to the single-cycle LEGv8 datapath.
//  Contains a register file, ALU, word-addressed data RAM and a small sequencer.
//  Control words are accepted through a valid/ready handshake. Each one executes over
//  EXEC/MEM/WB states, and the result is presented once on a registered write-back port.
//  Sits between the instruction-decode/control unit and the rest of the LEGv8 CPU.
// PARAMETERS
//  WIDTH      64   datapath, register and memory word width (bits), >=8
//  REGS       32   register count, power of 2; register REGS-1 is the zero register (XZR)
//  MEM_DEPTH  256  data RAM words, power of 2
//  RA_W = log2(REGS), MA_W = log2(MEM_DEPTH), CW_W = 3*RA_W+11 (localparams)
// PORTS
//  clock     in   1      rising-edge clock
//  reset     in   1      asynchronous, active-low reset
//  cw        in   CW_W   {SA,SB,DA,RegWrite,MemWrite,FS[4:0],Bsel,EN_Mem,EN_ALU,SetFlags}
//  cw_valid  in   1      cw and constant valid this cycle
//  cw_ready  out  1      sequencer idle; the word is accepted when cw_valid&&cw_ready
//  constant  in   WIDTH  immediate operand, used when Bsel=1
//  wb_data   out  WIDTH  write-back value (ALU or memory)
//  wb_valid  out  1      one-cycle pulse: wb_data valid, register write performed
//  status    out  4      {V,C,N,Z}, sticky flag register
//  err       out  1      sticky: illegal control word seen (EN_Mem&&EN_ALU)
// BEHAVIOUR
//  Reset (reset=0, async): all registers=0, RAM unchanged, state=IDLE, cw_ready=1,
//   wb_valid=0, wb_data=0, status=0, err=0. Reset mid-operation aborts the word:
//   no register write, no RAM write if not yet committed.
//  FSM: IDLE -> EXEC -> (MEM if EN_Mem) -> WB -> IDLE.
//   IDLE: cw_ready=1. On handshake, latch cw and constant, then go to EXEC. No other state accepts words.
//   EXEC: A=R[SA], B=Bsel?constant:R[SB]. Reads of REGS-1 return 0.
//     Latch ALU result. If SetFlags, update status from this op; otherwise status holds.
//     If MemWrite, RAM[alu[MA_W-1:0]] <= R[SB]; the unmuxed register value is stored.
//     If EN_Mem&&EN_ALU: set err, suppress RegWrite and MemWrite, go to WB (wb_data=0).
//   MEM: synchronous RAM read at alu[MA_W-1:0], 1-cycle latency, then WB.
//   WB: wb_valid=1. wb_data=EN_Mem?mem:EN_ALU?alu:0.
//     If RegWrite&&DA!=REGS-1, then R[DA]<=wb_data. Go to IDLE.
//  Latency: handshake in cycle 0; wb_valid in cycle 2 (ALU op) or cycle 3 (EN_Mem).
//   Next handshake is possible in cycle 3 or 4 respectively.
//  Address bits above MA_W-1 are ignored, so addresses wrap modulo MEM_DEPTH.
//  A load of an address stored by the previous word returns the new data.
//  ALU: FS[4:2] op: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 LSL, 101 LSR; 11x gives 0.
//   FS[1] inverts A and FS[0] inverts B before the op. For ADD, carry-in=FS[0].
//   Shifts use B[5:0] as shift amount (modulo WIDTH), applied to A.
//  Flags: Z=(F==0); N=F[WIDTH-1]; C=carry-out for ADD, else 0.
//   V=signed overflow for ADD, else 0.
//  err is sticky until reset.
// TESTING
//  1 Reset: after reset release, R[0..REGS-1]=0, status=0, cw_ready=1, wb_valid=0.
//  2 Immediate ADD: SA=31,DA=1,Bsel=1,const=5,FS=01000,RegWrite,EN_ALU ->
//    wb_valid in cycle 2 with wb_data=5, and R1=5.
//  3 SUBS with flags: R1=5, SUB const 5 (FS=01001), SetFlags -> wb_data=0, status=4'b0101 (C,Z).
//  4 Store/load: STUR R1 at addr 300 (MEM_DEPTH=256 wraps to 44), then load to R2 ->
//    R2=5, wb_valid in cycle 3, RAM[44]=5.
//  5 XZR and illegal word: write DA=31 leaves reads of R31 = 0.
//    EN_Mem=EN_ALU=1 -> err=1, no register/RAM change.
//  6 Back-pressure/reset: cw_valid held during EXEC is not accepted.
//    Drop reset in MEM -> no R write, wb_valid=0, state IDLE.

Source files
------------

// File: rtl/datapath_legv8_seq.sv
// Multi-cycle LEGv8 datapath: register file, ALU, word-addressed data RAM and an
// IDLE/EXEC/MEM/WB sequencer fed by a valid/ready control-word handshake.
module datapath_legv8_seq #(
    parameter int WIDTH     = 64,
    parameter int REGS      = 32,
    parameter int MEM_DEPTH = 256,
    localparam int RA_W     = $clog2(REGS),
    localparam int MA_W     = $clog2(MEM_DEPTH),
    localparam int CW_W     = 3*RA_W + 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CW_W-1:0]  cw,
    input  logic             cw_valid,
    output logic             cw_ready,
    input  logic [WIDTH-1:0] constant,
    output logic [WIDTH-1:0] wb_data,
    output logic             wb_valid,
    output logic [3:0]       status,
    output logic             err
);

    typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;

    localparam logic [RA_W-1:0] XZR = RA_W'(REGS-1);

    state_t           state;
    logic [CW_W-1:0]  cw_q;
    logic [WIDTH-1:0] const_q;
    logic [MA_W-1:0]  mem_addr_q;
    logic             reg_write_q;
    logic [WIDTH-1:0] regs [REGS];
    logic [WIDTH-1:0] ram  [MEM_DEPTH];

    logic [RA_W-1:0]  sa, sb, da;
    logic [4:0]       fs;
    logic             reg_write, mem_write, bsel, en_mem, en_alu, set_flags, illegal;

    assign sa        = cw_q[11+2*RA_W +: RA_W];
    assign sb        = cw_q[11+RA_W   +: RA_W];
    assign da        = cw_q[11        +: RA_W];
    assign reg_write = cw_q[10];
    assign mem_write = cw_q[9];
    assign fs        = cw_q[8:4];
    assign bsel      = cw_q[3];
    assign en_mem    = cw_q[2];
    assign en_alu    = cw_q[1];
    assign set_flags = cw_q[0];
    assign illegal   = en_mem && en_alu;

    assign cw_ready  = (state == IDLE);

    logic [WIDTH-1:0] reg_a, reg_b, a_in, b_in, alu_f, sum;
    logic [31:0]      shamt;
    logic             carry, flag_c, flag_v;

    // Operand fetch and ALU; XZR reads as zero regardless of array contents.
    always_comb begin
        reg_a  = (sa == XZR) ? '0 : regs[sa];
        reg_b  = (sb == XZR) ? '0 : regs[sb];
        a_in   = fs[1] ? ~reg_a : reg_a;
        b_in   = fs[0] ? ~(bsel ? const_q : reg_b) : (bsel ? const_q : reg_b);
        {carry, sum} = {1'b0, a_in} + {1'b0, b_in} + {{WIDTH{1'b0}}, fs[0]};
        shamt  = {26'd0, b_in[5:0]} % 32'(WIDTH);
        alu_f  = '0;
        flag_c = 1'b0;
        flag_v = 1'b0;
        case (fs[4:2])
            3'b000: alu_f = a_in & b_in;
            3'b001: alu_f = a_in | b_in;
            3'b010: begin
                alu_f  = sum;
                flag_c = carry;
                flag_v = (a_in[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != a_in[WIDTH-1]);
            end
            3'b011: alu_f = a_in ^ b_in;
            3'b100: alu_f = a_in << shamt;
            3'b101: alu_f = a_in >> shamt;
            default: alu_f = '0;
        endcase
    end

    // Sequencer, register file and write-back port share one reset domain.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cw_q        <= '0;
            const_q     <= '0;
            mem_addr_q  <= '0;
            reg_write_q <= 1'b0;
            wb_data     <= '0;
            wb_valid    <= 1'b0;
            status      <= 4'b0000;
            err         <= 1'b0;
            for (int i = 0; i < REGS; i++) regs[i] <= '0;
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cw_valid) begin
                        cw_q    <= cw;
                        const_q <= constant;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    mem_addr_q <= alu_f[MA_W-1:0];
                    if (set_flags)
                        status <= {flag_v, flag_c, alu_f[WIDTH-1], (alu_f == '0)};
                    reg_write_q <= reg_write && !illegal;
                    if (illegal) begin
                        err      <= 1'b1;
                        wb_data  <= '0;
                        wb_valid <= 1'b1;
                        state    <= WB;
                    end else if (en_mem) begin
                        state <= MEM;
                    end else begin
                        wb_data  <= en_alu ? alu_f : '0;
                        wb_valid <= 1'b1;
                        state    <= WB;
                    end
                end
                MEM: begin
                    wb_data  <= ram[mem_addr_q];
                    wb_valid <= 1'b1;
                    state    <= WB;
                end
                WB: begin
                    if (reg_write_q && da != XZR) regs[da] <= wb_data;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM contents survive reset; a store is blocked while reset is asserted.
    always_ff @(posedge clock) begin
        if (reset && state == EXEC && mem_write && !illegal)
            ram[alu_f[MA_W-1:0]] <= reg_b;
    end

endmodule
